alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the core's combinational ALU.
- Single-cycle logic/arith/shift ops produce a registered result one cycle after accept.
- Adds iterative unsigned multiply (shift-add) and divide (restoring), each WIDTH cycles.
- Valid/ready handshakes on input and output so the execute stage can stall on long ops.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU with valid/ready handshakes. Single-cycle ops
//            register their result on accept. Mul is iterative shift-add and
//            divu/remu are iterative restoring divide, one bit per cycle.
//            Divider present only when ALU_SEQ_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             z,
    output logic             busy
);

    localparam int               c_SHW  = $clog2(WIDTH);
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2,
        S_DIV  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic [c_SHW-1:0]     r_cnt;
    logic                 r_hi;
    logic [WIDTH-1:0]     r_rd;
    logic                 r_z;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_iter;
    logic [c_SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]     w_alu;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     w_step_res;

    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (ctrl[3:1] == 3'b101);
    assign w_shamt  = rs2[c_SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (ctrl)
            4'b0000: w_alu = rs1 + rs2;
            4'b0001: w_alu = rs1 - rs2;
            4'b0010: w_alu = rs1 & rs2;
            4'b0011: w_alu = rs1 | rs2;
            4'b0100: w_alu = rs1 ^ rs2;
            4'b0101: w_alu = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            4'b0110: w_alu = {{(WIDTH-1){1'b0}}, rs1 < rs2};
            4'b0111: w_alu = rs1 << w_shamt;
            4'b1000: w_alu = rs1 >> w_shamt;
            4'b1001: w_alu = $signed(rs1) >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Accumulator holds {high partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b & {WIDTH{r_acc[0]}}};
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [2*WIDTH-1:0]   w_div_nxt;

    // Accumulator holds {partial remainder, dividend bits shifting into quotient}.
    assign w_is_div    = (ctrl[3:1] == 3'b110);
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
    assign w_div_nxt   = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};
    assign w_step      = (r_state == S_DIV) ? w_div_nxt : w_mul_nxt;
    assign w_iter      = (r_state == S_MUL) || (r_state == S_DIV);
`else
    assign w_is_div    = 1'b0;
    assign w_step      = w_mul_nxt;
    assign w_iter      = (r_state == S_MUL);
`endif

    // Odd ctrl codes (mulhu, remu) take the upper half of the accumulator.
    assign w_step_res = r_hi ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul)      w_state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (w_is_div) w_state_nxt = S_DIV;
`endif
                    else               w_state_nxt = S_DONE;
                end
            end
            S_MUL:   if (r_cnt == c_LAST) w_state_nxt = S_DONE;
`ifdef ALU_SEQ_DIV_EN
            S_DIV:   if (r_cnt == c_LAST) w_state_nxt = S_DONE;
`endif
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_hi  <= 1'b0;
            r_rd  <= '0;
            r_z   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_acc <= {{WIDTH{1'b0}}, rs1};
                r_b   <= rs2;
                r_cnt <= '0;
                r_hi  <= ctrl[0];
                if (!w_is_mul && !w_is_div) begin
                    r_rd <= w_alu;
                    r_z  <= (w_alu == '0);
                end
            end
        end else if (w_iter) begin
            // The last iteration writes its result straight into rd.
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_rd <= w_step_res;
                r_z  <= (w_step_res == '0);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = w_iter;
    assign rd        = r_rd;
    assign z         = r_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq: directed cases plus random ops
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        z;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .z         (z),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: result straight from the operation's arithmetic meaning.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        int              sh;
        sh = int'(b % 32);
        p  = longint'(a) * longint'(b);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'(int'(a) >>> sh);
            4'd10: return p[31:0];
            4'd11: return p[63:32];
`ifdef ALU_SEQ_DIV_EN
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c);
        if (c == 4'd10 || c == 4'd11) return 33;
`ifdef ALU_SEQ_DIV_EN
        if (c == 4'd12 || c == 4'd13) return 33;
`endif
        return 1;
    endfunction

    // Issue one op from IDLE, wait for the result, check it, optionally hold
    // it unconsumed for some cycles, then consume and check the handshake.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        int bcyc;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; ctrl = c; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ctrl = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat  = 1;
        bcyc = 0;
        while (!out_valid && lat < 200) begin
            bcyc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_rd"},   rd,             exp);
        chk({tag, "_z"},    32'(z),         32'(exp == 32'd0));
        chk({tag, "_lat"},  32'(lat),       32'(exp_lat));
        chk({tag, "_busy"}, 32'(bcyc),      32'(exp_lat - 1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rd"},    rd,              exp);
            chk({tag, "_hold_ready"}, 32'(in_ready),   32'd0);
            chk({tag, "_hold_valid"}, 32'(out_valid),  32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_post_rd"},    rd,             exp);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;
        int          acc_n;
        int          res_n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ctrl = 4'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd",        rd,             32'd0);
        chk("rst_z",         32'(z),         32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;

        run_op("add",   4'b0000, 32'd20, 32'd30, 32'd50, 1, 3);
        run_op("sub",   4'b0001, 32'd8,  32'd3,  32'd5,  1, 0);
        run_op("subz",  4'b0001, 32'd20, 32'd20, 32'd0,  1, 0);
        run_op("slt",   4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
        run_op("sltu",  4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        run_op("sra",   4'b1001, 32'h8000_0000, 32'd33, 32'hC000_0000, 1, 0);
        run_op("mul",   4'b1010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 1);

        // Reset at iteration 10 of a multiply.
        in_valid = 1'b1; ctrl = 4'b1010; rs1 = 32'd12345; rs2 = 32'd678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midmul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_rd",        rd,             32'd0);
        run_op("add11", 4'b0000, 32'd1, 32'd1, 32'd2, 1, 0);

`ifdef ALU_SEQ_DIV_EN
        run_op("divu",  4'b1100, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu",  4'b1101, 32'd100, 32'd7, 32'd2,  33, 0);
        run_op("divu0", 4'b1100, 32'd5,   32'd0, 32'hFFFF_FFFF, 33, 0);
        run_op("remu0", 4'b1101, 32'd5,   32'd0, 32'd5,  33, 0);
`else
        run_op("divu_off", 4'b1100, 32'd100, 32'd7, 32'd0, 1, 0);
`endif
        run_op("rsvd", 4'b1110, 32'd9, 32'd9, 32'd0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op($sformatf("rnd%0d_op%0d", i, rc), rc, ra, rb, model(rc, ra, rb),
                   model_lat(rc), 0);
        end

        // Back-to-back issue with the consumer always ready.
        acc_n = 0;
        res_n = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; ctrl = 4'b0000;
            rs1 = 32'(i * 3); rs2 = 32'(100 + i);
            if (in_ready) begin
                q.push_back(32'(i * 3 + 100 + i));
                acc_n++;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                res_n++;
                if (q.size() > 0) chk("b2b_rd", rd, q.pop_front());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 32'(acc_n),    32'd10);
        chk("b2b_results", 32'(res_n),    32'(acc_n));
        chk("b2b_pending", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
